// File: rtl/note_sequencer_if.sv
// Bus between the note sequencer, its keyboard/control source, the song ROM
// and the buzzer. The sequencer side uses the master modport.
//
// Handshake semantics: start and stop are single-cycle pulses with no
// back-pressure; they are acted on at the clock edge where they are high.
// rom_data is the synchronous ROM output for the rom_addr presented one
// cycle earlier. note, rom_addr, beat are registered; playing and dbg_state
// are decoded straight from the state register.
interface note_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              stop;
    logic [6:0]        key_note;
    logic [11:0]       rom_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [6:0]        note;
    logic              playing;
    logic              beat;
    logic [2:0]        dbg_state;

    modport master (
        input  start, stop, key_note, rom_data,
        output rom_addr, note, playing, beat, dbg_state
    );

    modport slave (
        output start, stop, key_note, rom_data,
        input  rom_addr, note, playing, beat, dbg_state
    );
endinterface

// File: rtl/note_sequencer.sv
// Playback controller for the buzzer: free play from the keyboard in IDLE,
// otherwise steps through a song ROM with per-note durations and a silent
// gap after every song note so repeated notes re-articulate.
// Optional feature macro: LIVE_OVERRIDE_EN (a valid key pressed during
// PLAY/GAP replaces the song note on the output without disturbing timing).
module note_sequencer #(
    parameter int CLK_DIV    = 12_500_000,
    parameter int GAP_CYCLES = 2_500_000,
    parameter int ADDR_W     = 5,
    parameter int NOTE_MAX   = 21
) (
    input  logic              clk,
    input  logic              rst,
    note_sequencer_if.master  bus
);
    localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [6:0]        note_q, note_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              beat_q, beat_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [3:0]        beats_q, beats_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    // Song ROM entry fields.
    logic       ent_end;
    logic [3:0] ent_dur;
    logic [6:0] ent_note;
    assign ent_end  = bus.rom_data[11];
    assign ent_dur  = bus.rom_data[10:7];
    assign ent_note = bus.rom_data[6:0];

    // Out-of-range note indices are played as a rest.
    function automatic logic [6:0] clamp_note(input logic [6:0] n);
        return (n > 7'(NOTE_MAX)) ? 7'd0 : n;
    endfunction

`ifdef LIVE_OVERRIDE_EN
    logic [6:0] song_q, song_d;
    logic       key_valid;
    assign key_valid = (bus.key_note != 7'd0) && (bus.key_note <= 7'(NOTE_MAX));
`endif

    // State and datapath registers; reset wins over every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            note_q  <= '0;
            addr_q  <= '0;
            beat_q  <= 1'b0;
            tick_q  <= '0;
            beats_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            tick_q  <= tick_d;
            beats_q <= beats_d;
            gap_q   <= gap_d;
        end
    end

`ifdef LIVE_OVERRIDE_EN
    // Current song note, so the output can fall back to it on key release.
    always_ff @(posedge clk) begin
        if (rst) song_q <= '0;
        else     song_q <= song_d;
    end
`endif

    // Next-state and datapath decode; stop beats start, both beat normal flow.
    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        addr_d  = addr_q;
        beat_d  = 1'b0;
        tick_d  = tick_q;
        beats_d = beats_q;
        gap_d   = gap_q;
`ifdef LIVE_OVERRIDE_EN
        song_d  = song_q;
`endif
        case (state_q)
            IDLE: begin
                note_d = clamp_note(bus.key_note);
                if (bus.start && !bus.stop) begin
                    addr_d  = '0;
                    note_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                note_d  = '0;
                state_d = LOAD;
            end
            LOAD: begin
                if (ent_end || (ent_dur == 4'd0)) begin
                    note_d  = '0;
                    state_d = IDLE;
                end else begin
                    note_d  = clamp_note(ent_note);
`ifdef LIVE_OVERRIDE_EN
                    song_d  = clamp_note(ent_note);
`endif
                    beats_d = ent_dur;
                    tick_d  = '0;
                    beat_d  = 1'b1;
                    state_d = PLAY;
                end
            end
            PLAY: begin
`ifdef LIVE_OVERRIDE_EN
                note_d = key_valid ? bus.key_note : song_q;
`endif
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    beats_d = beats_q - 4'd1;
                    if (beats_q == 4'd1) begin
`ifdef LIVE_OVERRIDE_EN
                        note_d = key_valid ? bus.key_note : 7'd0;
`else
                        note_d = '0;
`endif
                        gap_d   = '0;
                        state_d = GAP;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            GAP: begin
`ifdef LIVE_OVERRIDE_EN
                note_d = key_valid ? bus.key_note : 7'd0;
`else
                note_d = '0;
`endif
                if (gap_q == GAP_LAST) begin
                    gap_d  = '0;
                    note_d = '0;
                    if (addr_q == {ADDR_W{1'b1}}) begin
                        addr_d  = '0;
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = FETCH;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                note_d  = '0;
            end
        endcase

        if (state_q != IDLE) begin
            if (bus.stop) begin
                state_d = IDLE;
                note_d  = '0;
                addr_d  = '0;
                beat_d  = 1'b0;
            end else if (bus.start) begin
                state_d = FETCH;
                note_d  = '0;
                addr_d  = '0;
                beat_d  = 1'b0;
            end
        end
    end

    assign bus.rom_addr  = addr_q;
    assign bus.note      = note_q;
    assign bus.beat      = beat_q;
    assign bus.playing   = (state_q != IDLE);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with CLK_DIV=4, GAP_CYCLES=2, ADDR_W=2.
// Expected note/beat/playing sequences are written out segment by segment.
module tb_note_sequencer;
    localparam int ADDR_W = 2;

    logic clk;
    logic rst;
    logic [11:0] rom [4];
    int n_checks;
    int n_bad;

    note_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    note_sequencer #(
        .CLK_DIV   (4),
        .GAP_CYCLES(2),
        .ADDR_W    (ADDR_W),
        .NOTE_MAX  (21)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / synchronous ROM model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    function automatic logic [11:0] ent(input bit e, input int dur, input int note);
        logic [3:0] d;
        logic [6:0] n;
        d = dur[3:0];
        n = note[6:0];
        return {e, d, n};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then read 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    // Check a run of len cycles with constant note, beat only on the first.
    task automatic run_seg(input string tag, input int exp_note, input int len, input bit first_beat);
        for (int i = 0; i < len; i++) begin
            check({tag, "_note"}, 32'(bus.note), exp_note);
            check({tag, "_beat"}, 32'(bus.beat), 32'((i == 0) && first_beat));
            check({tag, "_play"}, 32'(bus.playing), 1);
            cyc();
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_play"}, 32'(bus.playing), 0);
        check({tag, "_state"}, 32'(bus.dbg_state), 0);
        check({tag, "_note"}, 32'(bus.note), 0);
    endtask

    task automatic load_basic();
        rom[0] = ent(0, 2, 8);
        rom[1] = ent(0, 1, 8);
        rom[2] = ent(1, 0, 0);
        rom[3] = ent(0, 0, 0);
    endtask

    initial begin
        int ovr;
        n_checks = 0;
        n_bad    = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.key_note = 7'd0;
        load_basic();
        cyc();
        cyc();
        rst = 1'b0;
        check("por_note", 32'(bus.note), 0);
        check("por_addr", 32'(bus.rom_addr), 0);
        check("por_play", 32'(bus.playing), 0);
        check("por_beat", 32'(bus.beat), 0);

        // Reset mid-song, then free play.
        pulse_start();
        run_seg("r_pre", 0, 2, 0);
        run_seg("r_n0", 8, 3, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_note", 32'(bus.note), 0);
        check("rst_play", 32'(bus.playing), 0);
        check("rst_addr", 32'(bus.rom_addr), 0);
        check("rst_state", 32'(bus.dbg_state), 0);
        bus.key_note = 7'd12;
        check("free_lat", 32'(bus.note), 0);
        cyc();
        check("free_12", 32'(bus.note), 12);
        bus.key_note = 7'd30;
        cyc();
        check("free_30", 32'(bus.note), 0);
        bus.key_note = 7'd21;
        cyc();
        check("free_21", 32'(bus.note), 21);
        bus.key_note = 7'd0;
        cyc();

        // Basic song: 8 x8, gap 4, 8 x4, gap 4, end.
        pulse_start();
        check("b_addr0", 32'(bus.rom_addr), 0);
        run_seg("b_pre", 0, 2, 0);
        run_seg("b_n0", 8, 8, 1);
        run_seg("b_g0", 0, 4, 0);
        check("b_addr1", 32'(bus.rom_addr), 1);
        run_seg("b_n1", 8, 4, 1);
        run_seg("b_g1", 0, 4, 0);
        check_idle("b_end");

        // Invalid note plays as rest, zero duration ends playback.
        rom[0] = ent(0, 3, 25);
        rom[1] = ent(0, 0, 5);
        pulse_start();
        run_seg("z_pre", 0, 2, 0);
        run_seg("z_n0", 0, 12, 1);
        run_seg("z_g0", 0, 4, 0);
        check_idle("z_end");
        check("z_addr", 32'(bus.rom_addr), 1);

        // Stop mid-PLAY.
        load_basic();
        pulse_start();
        run_seg("s_pre", 0, 2, 0);
        run_seg("s_n0", 8, 3, 1);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        check_idle("s_stop");
        check("s_addr", 32'(bus.rom_addr), 0);

        // Restart during the second note.
        pulse_start();
        run_seg("t_pre", 0, 2, 0);
        run_seg("t_n0", 8, 8, 1);
        run_seg("t_g0", 0, 4, 0);
        check("t_addr1", 32'(bus.rom_addr), 1);
        run_seg("t_n1", 8, 2, 1);
        pulse_start();
        check("t_addr0", 32'(bus.rom_addr), 0);
        run_seg("t_pre2", 0, 2, 0);
        run_seg("t_n0b", 8, 4, 1);

        // start and stop together while playing: stop wins.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check_idle("ss");
        check("ss_addr", 32'(bus.rom_addr), 0);
        // start and stop together in IDLE: stays IDLE.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check_idle("ss_idle");

        // End of ROM without an end flag.
        for (int k = 0; k < 4; k++) rom[k] = ent(0, 1, 3 + k);
        pulse_start();
        run_seg("e_pre", 0, 2, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("e_addr%0d", k), 32'(bus.rom_addr), k);
            run_seg($sformatf("e_n%0d", k), 3 + k, 4, 1);
            run_seg($sformatf("e_g%0d", k), 0, (k == 3) ? 2 : 4, 0);
        end
        check_idle("e_end");
        check("e_addr_end", 32'(bus.rom_addr), 0);

        // Key held during a song note: replaces it only with the override.
`ifdef LIVE_OVERRIDE_EN
        ovr = 15;
`else
        ovr = 8;
`endif
        load_basic();
        pulse_start();
        run_seg("o_pre", 0, 2, 0);
        run_seg("o_n0a", 8, 2, 1);
        bus.key_note = 7'd15;
        run_seg("o_n0b", 8, 1, 0);
        run_seg("o_key", ovr, 2, 0);
        bus.key_note = 7'd0;
        run_seg("o_key3", ovr, 1, 0);
        run_seg("o_n0c", 8, 2, 0);
        run_seg("o_g0", 0, 4, 0);
        run_seg("o_n1", 8, 4, 1);
        run_seg("o_g1", 0, 4, 0);
        check_idle("o_end");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Playback controller in front of the piano buzzer tone generator. It selects the 7-bit note index sent to the buzzer, either from live keyboard input (free play) or from a song ROM that it steps through with per-note durations. It inserts a silent gap between consecutive song notes so that repeated notes re-articulate. It sits between the key decoder / song ROM and the buzzer.

## Interface
- CLK_DIV, 12_500_000 — clock cycles per duration tick (1/8 s at 100 MHz); must be ≥ 1
- GAP_CYCLES, 2_500_000 — silent cycles inserted after each song note; must be ≥ 1
- ADDR_W, 5 — song ROM address width; song length ≤ 2^ADDR_W entries
- NOTE_MAX, 21 — highest valid note index; larger values are played as rest (0)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin playback at ROM address 0
- stop  in  1  one-cycle pulse: abort playback
- key_note  in  7  live note from the keyboard decoder, 0 = none
- rom_data  in  12  song entry {end[11], dur[10:7], note[6:0]}; synchronous ROM, 1-cycle read latency
- rom_addr  out  ADDR_W  song ROM address, registered
- note  out  7  note index to the buzzer, registered, 0 = silence
- playing  out  1  high while a song is in progress (any state other than IDLE)
- beat  out  1  one-cycle pulse on the cycle the `note` output takes a new song note

## Operation
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE:
  - `note` ← `key_note`, or 0 if `key_note` > NOTE_MAX.
  - On `start`: `rom_addr` ← 0, `note` ← 0, go to FETCH.
- FETCH: waits one cycle for ROM data. `note` = 0.
- LOAD: samples `rom_data`.
  - If `end`=1 or `dur`=0: go to IDLE.
  - Otherwise: `note` ← data note (0 if > NOTE_MAX), beat counter ← `dur`, tick counter ← 0, `beat` = 1, go to PLAY.
- PLAY: tick counter counts 0..CLK_DIV−1. At wrap, the beat counter decrements. When the beat counter reaches 0 at a wrap: `note` ← 0, go to GAP.
- GAP: counts GAP_CYCLES cycles with `note` = 0.
  - If `rom_addr` = 2^ADDR_W−1: go to IDLE (end of ROM, no wrap-around).
  - Otherwise: `rom_addr` ← `rom_addr`+1, go to FETCH.
- `key_note` is ignored outside IDLE, except as described under Configuration.
- `stop` in any non-IDLE state: next state IDLE, `note` ← 0, `rom_addr` ← 0.
- `start` while playing restarts playback: `rom_addr` ← 0, `note` ← 0, go to FETCH.
- `start` and `stop` in the same cycle: `stop` wins.
- Width rules:
  - Tick counter is sized for CLK_DIV−1.
  - Beat counter is 4 bits.
  - GAP counter is sized for GAP_CYCLES−1.
  - No counter overflows for legal parameters.

## Timing
- Reset (synchronous, wins over every other input): state IDLE, `note`=0, `rom_addr`=0, `playing`=0, `beat`=0, all counters 0.
- Free-play latency: `key_note` reaches `note` one cycle after it is sampled.
- `start` sampled at edge N:
  - FETCH at N+1, LOAD at N+2.
  - First song note is visible on `note` after edge N+3, with `beat`=1 in that same cycle.
- A song note stays on `note` for exactly `dur`×CLK_DIV cycles.
- Silence between consecutive song notes lasts exactly GAP_CYCLES+2 cycles (GAP + FETCH + LOAD).
- `playing` rises the cycle after `start` is sampled. It falls the cycle after the terminating LOAD, final GAP, or `stop`.
- `stop` takes effect at the next edge; `note` is 0 the following cycle.

## Configuration
- LIVE_OVERRIDE_EN
  - Defined: during PLAY and GAP, a nonzero valid `key_note` drives `note` (1-cycle latency) in place of the song note. Song timing and `rom_addr` sequencing continue unaffected. When the key is released, the output returns to the current song note, or to 0 in GAP.
  - Undefined: `key_note` is ignored whenever `playing`=1.

## Test plan
- Reset and free play: assert `rst` mid-song, then apply `key_note`=12 in IDLE → `note`=0, `playing`=0, `rom_addr`=0 after reset; `note`=12 one cycle after the key is applied; `key_note`=30 → `note`=0.
- Basic song (CLK_DIV=4, GAP_CYCLES=2): ROM {note 8, dur 2}, {note 8, dur 1}, {end} → `note`=8 for 8 cycles, 0 for 4, 8 for 4, 0 for 4; `beat` pulses twice; `playing` falls after the end entry.
- Zero duration and invalid note: entry {note 25, dur 3} → `note`=0 for 12 cycles with `beat` still pulsing; entry {dur 0} → playback ends at that entry.
- Stop, restart, simultaneous inputs: `stop` mid-PLAY → `note`=0 and IDLE the next cycle; `start` mid-PLAY → `rom_addr`=0 and first note again 3 cycles later; `start`+`stop` together → IDLE.
- End of ROM (ADDR_W=2, no end flag in any entry) → 4 notes play, then IDLE after the 4th GAP; `rom_addr` returns to 0.
- LIVE_OVERRIDE_EN: `key_note`=15 held 3 cycles during a note-8 PLAY → `note`=15 for 3 cycles, then back to 8; total song timing unchanged versus the run without the key.
